// File: rtl/mpb_rr_arbiter.sv
// Round-robin arbiter sharing one MPB secondary between NUM_CH main channels.
// One transfer in flight at a time; the FSM returns to IDLE after every completion.
module mpb_rr_arbiter #(
  parameter int NUM_CH         = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            main_vld,
  input  logic [NUM_CH-1:0]            main_wr,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] main_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] main_wdata,
  output logic [NUM_CH-1:0]            main_rdy,
  output logic [DATA_WIDTH-1:0]        main_rdata,
  output logic                         sec_vld,
  output logic                         sec_wr,
  output logic [ADDR_WIDTH-1:0]        sec_addr,
  output logic [DATA_WIDTH-1:0]        sec_wdata,
  input  logic                         sec_rdy,
  input  logic [DATA_WIDTH-1:0]        sec_rdata,
  output logic [NUM_CH-1:0]            grant,
  output logic                         timeout_err
);

  localparam int IW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SW     = IW + 1;
  localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;
  localparam bit TO_EN  = (TIMEOUT_CYCLES > 0);
  localparam logic [TW-1:0] TLIM = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] g, g_nxt, g_adv;
  logic [IW-1:0] rr_ptr, rr_ptr_nxt;
  logic [IW-1:0] sel;
  logic          sel_vld;
  logic [SW-1:0] pos;
  logic [TW-1:0] tcnt, tcnt_nxt;

  assign g_adv = (g == IW'(NUM_CH - 1)) ? '0 : g + 1'b1;

  // Scan from the farthest offset down so the nearest requester at/after rr_ptr wins.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    pos     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      pos = {1'b0, rr_ptr} + SW'(i);
      if (pos >= SW'(NUM_CH)) pos = pos - SW'(NUM_CH);
      if (main_vld[pos[IW-1:0]]) begin
        sel     = pos[IW-1:0];
        sel_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    g_nxt       = g;
    rr_ptr_nxt  = rr_ptr;
    tcnt_nxt    = tcnt;
    sec_vld     = 1'b0;
    sec_wr      = 1'b0;
    sec_addr    = '0;
    sec_wdata   = '0;
    grant       = '0;
    main_rdy    = '0;
    main_rdata  = '0;
    timeout_err = 1'b0;
    case (state)
      IDLE: begin
        if (sel_vld) begin
          state_nxt = BUSY;
          g_nxt     = sel;
          tcnt_nxt  = '0;
        end
      end
      BUSY: begin
        grant[g]  = 1'b1;
        sec_wr    = main_wr[g];
        sec_addr  = main_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        sec_wdata = main_wdata[g*DATA_WIDTH +: DATA_WIDTH];
        // A main that withdraws its request mid-transfer forfeits its slot silently.
        if (!main_vld[g]) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = g_adv;
        end else begin
          sec_vld = 1'b1;
          if (sec_rdy) begin
            main_rdy[g] = !reset;
            main_rdata  = sec_rdata;
            state_nxt   = IDLE;
            rr_ptr_nxt  = g_adv;
          end else if (TO_EN && tcnt == TLIM) begin
            main_rdy[g] = !reset;
            main_rdata  = '1;
            timeout_err = !reset;
            state_nxt   = IDLE;
            rr_ptr_nxt  = g_adv;
          end else begin
            tcnt_nxt = tcnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      tcnt   <= '0;
      g      <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      tcnt   <= tcnt_nxt;
      g      <= g_nxt;
    end
  end

endmodule

// File: tb/tb_mpb_rr_arbiter.sv
// Scoreboard bench for mpb_rr_arbiter: a transaction-level model predicts every
// busy cycle and completion; a negedge monitor pops and compares.
module tb_mpb_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      main_vld, main_wr, main_rdy, grant;
  logic [N*AW-1:0]   main_addr;
  logic [N*DW-1:0]   main_wdata;
  logic [DW-1:0]     main_rdata, sec_wdata, sec_rdata;
  logic [AW-1:0]     sec_addr;
  logic              sec_vld, sec_wr, sec_rdy, timeout_err;

  always #5 clk = ~clk;

  mpb_rr_arbiter #(.NUM_CH(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .main_vld(main_vld), .main_wr(main_wr),
    .main_addr(main_addr), .main_wdata(main_wdata), .main_rdy(main_rdy),
    .main_rdata(main_rdata), .sec_vld(sec_vld), .sec_wr(sec_wr),
    .sec_addr(sec_addr), .sec_wdata(sec_wdata), .sec_rdy(sec_rdy),
    .sec_rdata(sec_rdata), .grant(grant), .timeout_err(timeout_err));

  typedef struct {int cyc; int ch; bit svld; bit wr; logic [AW-1:0] addr; logic [DW-1:0] wdata;} req_t;
  typedef struct {int cyc; int ch; logic [DW-1:0] rdata; bit terr;} cpl_t;

  req_t req_q[$];
  cpl_t cpl_q[$];
  cpl_t log_q[$];

  int  n_chk = 0, n_fail = 0, cyc = 0;
  bit  mon_en = 1'b0;

  // Stimulus-side view of each main and of the secondary
  bit              pend [N];
  logic            wr_h [N];
  logic [AW-1:0]   addr_h [N];
  logic [DW-1:0]   wd_h [N];
  bit              s_rdy, rst_d;
  logic [DW-1:0]   s_rdata;

  // Reference model: which channel is being served, how long, and whose turn is next
  bit  m_busy = 1'b0;
  int  m_g = 0, m_ptr = 0, m_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive();
    reset = rst_d;
    for (int c = 0; c < N; c++) begin
      main_vld[c]              = pend[c];
      main_wr[c]               = wr_h[c];
      main_addr[c*AW +: AW]    = addr_h[c];
      main_wdata[c*DW +: DW]   = wd_h[c];
    end
    sec_rdy   = s_rdy;
    sec_rdata = s_rdata;
  endtask

  task automatic model();
    req_t r;
    cpl_t e;
    bit   found;
    if (m_busy) begin
      r.cyc = cyc; r.ch = m_g; r.svld = pend[m_g]; r.wr = wr_h[m_g];
      r.addr = addr_h[m_g]; r.wdata = wd_h[m_g];
      req_q.push_back(r);
      if (!rst_d) begin
        if (!pend[m_g]) begin
          m_busy = 1'b0;
          m_ptr  = (m_g + 1) % N;
        end else if (s_rdy || (m_cnt + 1 == TO)) begin
          e.cyc = cyc; e.ch = m_g; e.terr = !s_rdy;
          e.rdata = s_rdy ? s_rdata : {DW{1'b1}};
          cpl_q.push_back(e);
          pend[m_g] = 1'b0;
          m_busy    = 1'b0;
          m_ptr     = (m_g + 1) % N;
        end else begin
          m_cnt++;
        end
      end
    end else if (!rst_d) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!found && pend[(m_ptr + k) % N]) begin
          found  = 1'b1;
          m_g    = (m_ptr + k) % N;
          m_busy = 1'b1;
          m_cnt  = 0;
        end
      end
    end
    if (rst_d) begin
      m_busy = 1'b0;
      m_ptr  = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step();
    drive();
    model();
    tick();
  endtask

  task automatic req(input int c, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[c] = 1'b1; wr_h[c] = w; addr_h[c] = a; wd_h[c] = d;
  endtask

  // Monitor: pops an expectation whenever the DUT shows a busy cycle or a completion
  req_t mr;
  cpl_t mc, ml;
  always @(negedge clk) begin
    if (mon_en) begin
      if (grant != '0 || sec_vld) begin
        if (req_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL busy_unexpected: grant %h sec_vld %0d, none expected (cycle %0d)", grant, sec_vld, cyc);
        end else begin
          mr = req_q.pop_front();
          chk("busy_cycle", cyc, mr.cyc);
          chk("grant", 32'(grant), 32'(1) << mr.ch);
          chk("sec_vld", 32'(sec_vld), 32'(mr.svld));
          chk("sec_wr", 32'(sec_wr), 32'(mr.wr));
          chk("sec_addr", sec_addr, mr.addr);
          chk("sec_wdata", sec_wdata, mr.wdata);
        end
      end
      if (main_rdy != '0 || timeout_err) begin
        ml.cyc = cyc; ml.rdata = main_rdata; ml.terr = timeout_err; ml.ch = -1;
        for (int i = 0; i < N; i++) if (main_rdy[i]) ml.ch = i;
        log_q.push_back(ml);
        if (cpl_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL cpl_unexpected: main_rdy %h timeout_err %0d, none expected (cycle %0d)", main_rdy, timeout_err, cyc);
        end else begin
          mc = cpl_q.pop_front();
          chk("cpl_cycle", cyc, mc.cyc);
          chk("main_rdy", 32'(main_rdy), 32'(1) << mc.ch);
          chk("main_rdata", main_rdata, mc.rdata);
          chk("timeout_err", 32'(timeout_err), 32'(mc.terr));
        end
      end
    end
  end

  initial begin
    int a, l0;
    for (int c = 0; c < N; c++) begin
      pend[c] = 1'b0; wr_h[c] = 1'b0; addr_h[c] = '0; wd_h[c] = '0;
    end
    s_rdy = 1'b0; s_rdata = '0; rst_d = 1'b1;
    step();
    mon_en = 1'b1;
    step();
    rst_d = 1'b0;

    // Reset state
    drive(); #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_sec_vld", 32'(sec_vld), 0);
    chk("rst_main_rdy", 32'(main_rdy), 0);
    chk("rst_main_rdata", main_rdata, 0);
    chk("rst_sec_addr", sec_addr, 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    model(); tick();

    // Single read on ch2, secondary answers after 3 cycles
    l0 = log_q.size(); a = cyc;
    req(2, 1'b0, 32'h100, 32'h0);
    step(); step(); step();
    s_rdy = 1'b1; s_rdata = 32'hDEADBEEF; step();
    s_rdy = 1'b0; step(); step();
    chk("rd_count", log_q.size() - l0, 1);
    chk("rd_ch", log_q[l0].ch, 2);
    chk("rd_data", log_q[l0].rdata, 32'hDEADBEEF);
    chk("rd_cycle", log_q[l0].cyc - a, 3);

    // Fairness: everyone requests continuously, zero-wait secondary
    rst_d = 1'b1; step(); rst_d = 1'b0;
    l0 = log_q.size();
    s_rdy = 1'b1;
    for (int n = 0; n < 16; n++) begin
      for (int c = 0; c < N; c++)
        if (!pend[c]) req(c, 1'(n & 1), 32'h1000 + 32'(c * 16 + n), $urandom);
      s_rdata = $urandom;
      step();
    end
    for (int c = 0; c < N; c++) pend[c] = 1'b0;
    s_rdy = 1'b0; step(); step();
    chk("fair_count", log_q.size() - l0, 8);
    for (int k = 0; k < 8 && l0 + k < log_q.size(); k++) begin
      chk("fair_order", log_q[l0 + k].ch, k % N);
      if (k > 0) chk("fair_spacing", log_q[l0 + k].cyc - log_q[l0 + k - 1].cyc, 2);
    end

    // Timeout on a ch1 write
    l0 = log_q.size(); a = cyc;
    req(1, 1'b1, 32'h2000, 32'hCAFE0001);
    for (int n = 0; n < 17; n++) step();
    step(); step();
    chk("to_count", log_q.size() - l0, 1);
    chk("to_ch", log_q[l0].ch, 1);
    chk("to_data", log_q[l0].rdata, 32'hFFFFFFFF);
    chk("to_err", 32'(log_q[l0].terr), 1);
    chk("to_cycle", log_q[l0].cyc - a, 16);

    // Race: sec_rdy arrives in the 16th busy cycle
    l0 = log_q.size(); a = cyc;
    req(2, 1'b0, 32'h3000, 32'h0);
    for (int n = 0; n < 16; n++) step();
    s_rdy = 1'b1; s_rdata = 32'h12345678; step();
    s_rdy = 1'b0; step();
    chk("race_count", log_q.size() - l0, 1);
    chk("race_data", log_q[l0].rdata, 32'h12345678);
    chk("race_err", 32'(log_q[l0].terr), 0);
    chk("race_cycle", log_q[l0].cyc - a, 16);

    // Reset while serving ch3, then ch0 and ch3 both pending
    l0 = log_q.size();
    req(3, 1'b1, 32'h4000, 32'h33);
    step(); step(); step();
    rst_d = 1'b1; req(0, 1'b0, 32'h4100, 32'h0); step();
    rst_d = 1'b0;
    drive(); #1;
    chk("rstb_sec_vld", 32'(sec_vld), 0);
    chk("rstb_grant", 32'(grant), 0);
    chk("rstb_main_rdy", 32'(main_rdy), 0);
    model(); tick();
    s_rdy = 1'b1; s_rdata = 32'hA0; step();
    s_rdy = 1'b0; step();
    s_rdy = 1'b1; s_rdata = 32'hA3; step();
    s_rdy = 1'b0; step();
    chk("rstb_count", log_q.size() - l0, 2);
    chk("rstb_first", log_q[l0].ch, 0);
    chk("rstb_second", log_q[l0 + 1].ch, 3);

    // Protocol violation: ch0 drops vld while busy, ch1 waiting
    l0 = log_q.size();
    req(0, 1'b0, 32'h5000, 32'h0);
    req(1, 1'b1, 32'h5100, 32'h51);
    step(); step();
    pend[0] = 1'b0;
    drive(); #1;
    chk("drop_sec_vld", 32'(sec_vld), 0);
    chk("drop_main_rdy", 32'(main_rdy), 0);
    chk("drop_timeout_err", 32'(timeout_err), 0);
    model(); tick();
    step();
    s_rdy = 1'b1; s_rdata = 32'h55; step();
    s_rdy = 1'b0; step();
    chk("drop_count", log_q.size() - l0, 1);
    chk("drop_next_ch", log_q[l0].ch, 1);

    // Randomized traffic with drops, slow phases and occasional resets
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < N; c++)
        if (!pend[c] && $urandom_range(0, 3) == 0)
          req(c, 1'($urandom_range(0, 1)), $urandom, $urandom);
      if (m_busy && pend[m_g] && $urandom_range(0, 39) == 0) pend[m_g] = 1'b0;
      if ((n % 600) < 150) s_rdy = ($urandom_range(0, 19) == 0);
      else                 s_rdy = ($urandom_range(0, 2) == 0);
      s_rdata = $urandom;
      rst_d   = ($urandom_range(0, 499) == 0);
      step();
    end
    rst_d = 1'b0; s_rdy = 1'b0;
    for (int c = 0; c < N; c++) pend[c] = 1'b0;
    step(); step(); step();
    chk("req_q_left", req_q.size(), 0);
    chk("cpl_q_left", cpl_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mpb_rr_arbiter.md
MPB_RR_ARBITER -- requirements
Module: mpb_rr_arbiter

Interface
REQ-001 Parameter NUM_CH, default 4: number of MPB main channels, legal range 2..16.
REQ-002 Parameter DATA_WIDTH, default 32: width of the read and write data buses.
REQ-003 Parameter ADDR_WIDTH, default 32: width of the address bus.
REQ-004 Parameter TIMEOUT_CYCLES, default 256: secondary response limit in cycles; 0 disables the timeout.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  system clock; all state updates on posedge.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 main_vld  in  NUM_CH  per-channel request valid.
REQ-009 main_wr  in  NUM_CH  per-channel write (1) / read (0).
REQ-010 main_addr  in  NUM_CH*ADDR_WIDTH  packed per-channel address; channel i occupies slice i.
REQ-011 main_wdata  in  NUM_CH*DATA_WIDTH  packed per-channel write data.
REQ-012 main_rdy  out  NUM_CH  per-channel completion strobe.
REQ-013 main_rdata  out  DATA_WIDTH  read data, shared by all channels.
REQ-014 sec_vld, sec_wr  out  1 each  request to the secondary.
REQ-015 sec_addr  out  ADDR_WIDTH  address to the secondary.
REQ-016 sec_wdata  out  DATA_WIDTH  write data to the secondary.
REQ-017 sec_rdy  in  1  secondary completion.
REQ-018 sec_rdata  in  DATA_WIDTH  secondary read data.
REQ-019 grant  out  NUM_CH  one-hot index of the channel being served; all zero when idle.
REQ-020 timeout_err  out  1  one-cycle pulse on a timed-out transfer.

Function
REQ-021 A transfer completes on the cycle where vld=1 and rdy=1 at posedge clk; a main SHALL hold its addr, wr and wdata stable while vld=1 and rdy=0.
REQ-022 The FSM SHALL have exactly two states, IDLE and BUSY.
REQ-023 IDLE: sec_vld=0, sec_wr=0, sec_addr=0, sec_wdata=0, grant=0, main_rdy=0, main_rdata=0.
REQ-024 IDLE with any main_vld set: select the first requesting channel at or after rr_ptr (modulo NUM_CH), latch it as the granted channel g, and enter BUSY on the next cycle.
REQ-025 Arbitration latency SHALL be exactly 1 cycle from main_vld rising to sec_vld rising.
REQ-026 BUSY: grant=onehot(g), sec_vld=1, and sec_wr, sec_addr and sec_wdata are driven combinationally from channel g.
REQ-027 BUSY with sec_rdy=1: main_rdy[g]=1 and main_rdata=sec_rdata in the same cycle; next state IDLE; rr_ptr=(g+1) mod NUM_CH.
REQ-028 main_rdy SHALL be zero for every channel other than g in all cycles.
REQ-029 Peak throughput SHALL be one transfer per 2 cycles, because the FSM returns to IDLE after every completion.
REQ-030 The grant SHALL be locked for the whole of BUSY; new requests are ignored until IDLE.
REQ-031 Timeout counter: cleared on entry to BUSY; increments each BUSY cycle with sec_rdy=0; width is clog2(TIMEOUT_CYCLES+1).
REQ-032 When the counter equals TIMEOUT_CYCLES-1 and sec_rdy=0 (TIMEOUT_CYCLES>0), the block SHALL assert main_rdy[g]=1, drive main_rdata to all ones and pulse timeout_err=1, then enter IDLE with rr_ptr advanced.
REQ-033 If sec_rdy=1 and the timeout condition occur in the same cycle, the block SHALL complete normally with no timeout_err.
REQ-034 If main_vld[g] drops during BUSY (protocol violation), the block SHALL force sec_vld=0 in that cycle and enter IDLE next cycle; no main_rdy is issued, rr_ptr advances and timeout_err stays 0.
REQ-035 A request arriving on channel g in the same cycle it completes SHALL be treated as a new request and arbitrated in the following IDLE cycle.

Reset
REQ-036 Synchronous reset SHALL force state=IDLE, rr_ptr=0, timeout counter=0 and timeout_err=0; all outputs take their IDLE values on the next cycle.
REQ-037 Reset asserted during BUSY SHALL abandon the transfer: no main_rdy is issued and sec_vld=0 from the next cycle.

Verification
REQ-038 Single read: ch2 vld with addr 0x100, secondary rdy after 3 cycles with rdata 0xDEADBEEF -> sec_vld high 1 cycle after request, main_rdy[2] pulses once with rdata 0xDEADBEEF.
REQ-039 Fairness: all 4 channels request continuously, secondary has zero wait -> grant order 0,1,2,3,0,..., one completion every 2 cycles.
REQ-040 Timeout: TIMEOUT_CYCLES=16, ch1 write, sec_rdy held 0 -> main_rdy[1] and timeout_err both pulse in the 16th BUSY cycle, rdata 0xFFFFFFFF.
REQ-041 Race: sec_rdy arrives in the 16th BUSY cycle -> normal completion with sec_rdata returned and timeout_err=0.
REQ-042 Reset mid-BUSY on ch3 -> next cycle sec_vld=0 and grant=0; no main_rdy; next request with ch0 and ch3 both pending grants ch0.
REQ-043 Protocol violation: ch0 drops vld in BUSY -> sec_vld=0 that cycle, no main_rdy, and the next grant goes to ch1 if it is requesting.
